// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types, constants and helpers for the multi-port register file
package regfile_pkg;

    typedef enum logic {
        RF_CLEAR = 1'b0,
        RF_RUN   = 1'b1
    } rf_state_t;

    localparam int unsigned RF_ZERO_ADR = 0;

    function automatic int rf_aw(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// rtl/regfile_rd_port.sv - one combinational read port with zero-register masking and write bypass
module regfile_rd_port #(
    parameter int XLEN     = 32,
    parameter int AW       = 5,
    parameter int NWR      = 1,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic              run_i,
    input  logic [AW-1:0]     adr_i,
    input  logic [XLEN-1:0]   stored_i,
    input  logic [NWR-1:0]    we_i,
    input  logic [NWR*AW-1:0] w_adr_i,
    input  logic [NWR*XLEN-1:0] w_data_i,
    output logic [XLEN-1:0]   rd_o
);
    import regfile_pkg::*;

    logic is_zero;

    assign is_zero = (ZERO_REG != 0) && (adr_i == AW'(RF_ZERO_ADR));

    // Ascending scan lets the highest-index matching writer win, mirroring the array update.
    always_comb begin
        rd_o = stored_i;
        if (BYPASS != 0) begin
            for (int k = 0; k < NWR; k++) begin
                if (we_i[k] && (w_adr_i[k*AW +: AW] == adr_i)) begin
                    rd_o = w_data_i[k*XLEN +: XLEN];
                end
            end
        end
        if (!run_i || is_zero) begin
            rd_o = '0;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - parametrised multi-port register file with clear sequencer and write bypass
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int NRD      = 2,
    parameter int NWR      = 1,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1,
    localparam int AW      = rf_aw(NREGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic [NWR-1:0]      we,
    input  logic [NWR*AW-1:0]   w_adr,
    input  logic [NWR*XLEN-1:0] w_data,
    input  logic [NRD*AW-1:0]   adr,
    output logic [NRD*XLEN-1:0] rd,
    output logic                busy
);

    rf_state_t       state_q, state_d;
    logic [AW-1:0]   ptr_q, ptr_d;
    logic [XLEN-1:0] ram_q [NREGS];
    logic            run;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RF_CLEAR;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        if (clr) begin
            state_d = RF_CLEAR;
            ptr_d   = '0;
        end else if (state_q == RF_CLEAR) begin
            ptr_d = ptr_q + AW'(1);
            if (ptr_q == AW'(NREGS - 1)) begin
                state_d = RF_RUN;
            end
        end
    end

    always_comb begin
        busy = (state_q == RF_CLEAR);
        run  = (state_q == RF_RUN);
    end

    // No reset on the array: the sequencer zeroes it, and a clr edge in RUN discards user writes.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state_q == RF_CLEAR) begin
                ram_q[ptr_q] <= '0;
            end else if (!clr) begin
                for (int k = 0; k < NWR; k++) begin
                    if (we[k] && !((ZERO_REG != 0) && (w_adr[k*AW +: AW] == AW'(RF_ZERO_ADR)))) begin
                        ram_q[w_adr[k*AW +: AW]] <= w_data[k*XLEN +: XLEN];
                    end
                end
            end
        end
    end

    for (genvar j = 0; j < NRD; j++) begin : g_rd
        regfile_rd_port #(
            .XLEN     (XLEN),
            .AW       (AW),
            .NWR      (NWR),
            .BYPASS   (BYPASS),
            .ZERO_REG (ZERO_REG)
        ) u_rd (
            .run_i    (run),
            .adr_i    (adr[j*AW +: AW]),
            .stored_i (ram_q[adr[j*AW +: AW]]),
            .we_i     (we),
            .w_adr_i  (w_adr),
            .w_data_i (w_data),
            .rd_o     (rd[j*XLEN +: XLEN])
        );
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - self-checking bench for regfile_mp (bypass/2-write instance plus no-bypass instance)
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        rst_n, clr;
    logic [1:0]  we;
    logic [9:0]  w_adr;
    logic [63:0] w_data;
    logic [9:0]  adr;
    logic [63:0] rd;
    logic        busy;

    logic [0:0]  nb_we;
    logic [4:0]  nb_w_adr;
    logic [31:0] nb_w_data;
    logic [4:0]  nb_adr;
    logic [31:0] nb_rd;
    logic        nb_busy;

    int checks = 0;
    int failures = 0;

    logic [31:0] mem [32];
    int          clear_left = 32;

    typedef struct {
        logic [1:0]  we;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic [4:0]  a0;
        logic [4:0]  a1;
        logic [31:0] e0;
        logic [31:0] e1;
    } vec_t;

    vec_t tbl [11];

    always #5 clk = ~clk;

    regfile_mp #(
        .XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .BYPASS(1), .ZERO_REG(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .we(we), .w_adr(w_adr),
        .w_data(w_data), .adr(adr), .rd(rd), .busy(busy)
    );

    regfile_mp #(
        .XLEN(32), .NREGS(32), .NRD(1), .NWR(1), .BYPASS(0), .ZERO_REG(1)
    ) dut_nb (
        .clk(clk), .rst_n(rst_n), .clr(clr), .we(nb_we), .w_adr(nb_w_adr),
        .w_data(nb_w_data), .adr(nb_adr), .rd(nb_rd), .busy(nb_busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference read: zero during clear or for x0, else newest same-cycle write, else stored.
    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        logic [31:0] v;
        if (clear_left > 0 || a == 5'd0) return 32'd0;
        v = mem[a];
        for (int k = 0; k < 2; k++)
            if (we[k] && w_adr[k*5 +: 5] == a) v = w_data[k*32 +: 32];
        return v;
    endfunction

    task automatic step();
        #1;
        chk("busy", 32'(busy), (clear_left > 0) ? 32'd1 : 32'd0);
        chk("rd0", rd[31:0], exp_rd(adr[4:0]));
        chk("rd1", rd[63:32], exp_rd(adr[9:5]));
        @(posedge clk);
        if (!rst_n || clr) begin
            clear_left = 32;
            for (int i = 0; i < 32; i++) mem[i] = '0;
        end else if (clear_left > 0) begin
            clear_left--;
        end else begin
            for (int k = 0; k < 2; k++)
                if (we[k] && w_adr[k*5 +: 5] != 5'd0) mem[w_adr[k*5 +: 5]] = w_data[k*32 +: 32];
        end
        @(negedge clk);
    endtask

    task automatic drive(input logic [1:0] w, input logic [4:0] wa0, input logic [31:0] wd0,
                         input logic [4:0] wa1, input logic [31:0] wd1,
                         input logic [4:0] a0, input logic [4:0] a1);
        we     = w;
        w_adr  = {wa1, wa0};
        w_data = {wd1, wd0};
        adr    = {a1, a0};
    endtask

    task automatic count_busy(input string name, input int exp_cnt);
        int n;
        n = 0;
        for (int i = 0; i < 100; i++) begin
            #1;
            if (!busy) break;
            n++;
            step();
        end
        chk(name, 32'(n), 32'(exp_cnt));
    endtask

    task automatic check_all_zero(input string name);
        for (int i = 0; i < 32; i++) begin
            drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 5'(i), 5'(31 - i));
            #1;
            chk(name, rd[31:0], 32'd0);
            step();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{2'b01, 5, 32'hDEADBEEF, 0, 0, 5, 6, 32'hDEADBEEF, 32'h0};
        tbl[1]  = '{2'b00, 0, 0, 0, 0, 5, 0, 32'hDEADBEEF, 32'h0};
        tbl[2]  = '{2'b11, 7, 32'h11111111, 7, 32'h22222222, 7, 7, 32'h22222222, 32'h22222222};
        tbl[3]  = '{2'b00, 0, 0, 0, 0, 7, 5, 32'h22222222, 32'hDEADBEEF};
        tbl[4]  = '{2'b11, 0, 32'h12345678, 9, 32'hCAFEF00D, 0, 9, 32'h0, 32'hCAFEF00D};
        tbl[5]  = '{2'b00, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0};
        tbl[6]  = '{2'b10, 0, 0, 9, 32'h0BADF00D, 10, 9, 32'h0, 32'h0BADF00D};
        tbl[7]  = '{2'b01, 10, 32'h01020304, 10, 32'hFFFFFFFF, 10, 9, 32'h01020304, 32'h0BADF00D};
        tbl[8]  = '{2'b00, 0, 0, 0, 0, 10, 7, 32'h01020304, 32'h22222222};
        tbl[9]  = '{2'b11, 0, 32'h12345678, 0, 32'h87654321, 0, 0, 32'h0, 32'h0};
        tbl[10] = '{2'b00, 0, 0, 0, 0, 0, 9, 32'h0, 32'h0BADF00D};

        rst_n = 1'b0; clr = 1'b0;
        drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 5'd3, 5'd4);
        nb_we = 1'b0; nb_w_adr = '0; nb_w_data = '0; nb_adr = 5'd1;
        repeat (3) @(posedge clk);
        @(negedge clk);

        // Reset and initial clear
        step();
        step();
        rst_n = 1'b1;
        count_busy("reset_busy_len", 32);
        chk("nb_busy_after_reset", 32'(nb_busy), 32'd0);
        check_all_zero("reset_zero");

        // Directed vectors on the bypass instance
        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].we, tbl[i].wa0, tbl[i].wd0, tbl[i].wa1, tbl[i].wd1, tbl[i].a0, tbl[i].a1);
            #1;
            chk($sformatf("tbl%0d_rd0", i), rd[31:0], tbl[i].e0);
            chk($sformatf("tbl%0d_rd1", i), rd[63:32], tbl[i].e1);
            step();
        end
        drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 5'd0);

        // No-bypass instance: new value appears the cycle after the write
        nb_we = 1'b1; nb_w_adr = 5'd5; nb_w_data = 32'hDEADBEEF; nb_adr = 5'd5;
        #1;
        chk("nb_old_value", nb_rd, 32'd0);
        step();
        nb_we = 1'b1; nb_w_adr = 5'd0; nb_w_data = 32'h12345678; nb_adr = 5'd5;
        #1;
        chk("nb_new_value", nb_rd, 32'hDEADBEEF);
        step();
        nb_we = 1'b0; nb_adr = 5'd0;
        #1;
        chk("nb_x0_next", nb_rd, 32'd0);
        step();

        // Randomised traffic with occasional soft clears
        for (int i = 0; i < 400; i++) begin
            logic [4:0] wa0, wa1, a0, a1;
            wa0 = 5'($urandom_range(0, 7));
            wa1 = ($urandom_range(0, 3) == 0) ? wa0 : 5'($urandom_range(0, 31));
            a0  = ($urandom_range(0, 1) == 0) ? wa0 : 5'($urandom_range(0, 31));
            a1  = ($urandom_range(0, 1) == 0) ? wa1 : 5'($urandom_range(0, 31));
            drive(2'($urandom_range(0, 3)), wa0, $urandom, wa1, $urandom, a0, a1);
            clr = ($urandom_range(0, 39) == 0);
            step();
        end
        clr = 1'b0;
        drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 5'd1, 5'd2);
        for (int i = 0; i < 40 && clear_left > 0; i++) step();
        #1;
        chk("idle_before_softclr", 32'(busy), 32'd0);

        // Soft clear mid-operation discards the same-cycle write
        for (int i = 1; i < 32; i++) begin
            drive(2'b01, 5'(i), 32'h10000000 + 32'(i) * 32'h01010101, 5'd0, 32'd0, 5'(i), 5'd3);
            step();
        end
        drive(2'b01, 5'd3, 32'hAAAA5555, 5'd0, 32'd0, 5'd3, 5'd4);
        clr = 1'b1;
        step();
        clr = 1'b0;
        drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 5'd3, 5'd4);
        count_busy("softclr_busy_len", 32);
        drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 5'd3, 5'd3);
        #1;
        chk("x3_after_clr", rd[31:0], 32'd0);
        check_all_zero("softclr_zero");

        // Reset during clear restarts the count
        clr = 1'b1;
        step();
        clr = 1'b0;
        repeat (10) step();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        count_busy("rst_restart_busy_len", 32);
        chk("nb_busy_final", 32'(nb_busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
